multicycle_control_unit: RTL and testbench

- Multi-cycle control FSM that drives every control input of the processor DataPath and consumes its ALU result and flags.
- Owns the PC and the instruction-memory fetch port.
- Sequences fetch, decode, execute, memory and writeback.
- Instantiated beside DataPath in the processor top level.

---
 rtl/multicycle_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the DataPath: owns the PC and the fetch port, and
// sequences fetch, decode, execute, memory and writeback for each instruction.
module multicycle_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  ALU_ADD  = 4'b0000,
  parameter logic [3:0]  ALU_SUB  = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic [31:0] alu_result1,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        sign_flag,
  input  logic        overflow_flag,
  output logic        regWriteEnable,
  output logic        regWrite_select,
  output logic        reg_to_pc,
  output logic        reg_data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALU_src,
  output logic        const_src,
  output logic [4:0]  regAddr_1,
  output logic [4:0]  regAddr_2,
  output logic [5:0]  shift_amount,
  output logic [15:0] immediate_const,
  output logic [3:0]  alu_control,
  output logic [31:0] npc,
  output logic [3:0]  flags_q,
  output logic        halted,
  output logic        illegal_op
);

  localparam logic [5:0] OP_RALU  = 6'h00;
  localparam logic [5:0] OP_SHIFT = 6'h01;
  localparam logic [5:0] OP_ADDI  = 6'h02;
  localparam logic [5:0] OP_LD    = 6'h03;
  localparam logic [5:0] OP_ST    = 6'h04;
  localparam logic [5:0] OP_BR    = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h06;
  localparam logic [5:0] OP_BNE   = 6'h07;
  localparam logic [5:0] OP_CALL  = 6'h08;
  localparam logic [5:0] OP_RET   = 6'h09;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic        reg_write_select;
    logic        reg_to_pc;
    logic        reg_data;
    logic        alu_src;
    logic        const_src;
    logic [4:0]  reg_addr_1;
    logic [4:0]  reg_addr_2;
    logic [5:0]  shift_amount;
    logic [15:0] imm;
    logic [3:0]  alu_control;
  } ctrl_t;

  // Static DataPath controls implied by one instruction word.
  function automatic ctrl_t decode_ctrl(input logic [31:0] ir);
    ctrl_t c;
    c              = '0;
    c.reg_addr_1   = ir[25:21];
    c.reg_addr_2   = ir[20:16];
    c.shift_amount = ir[15:10];
    c.imm          = ir[15:0];
    case (ir[31:26])
      OP_RALU: begin
        c.alu_control = ir[3:0];
        c.reg_data    = 1'b1;
      end
      OP_SHIFT: begin
        c.alu_src     = 1'b1;
        c.const_src   = 1'b1;
        c.alu_control = ir[3:0];
        c.reg_data    = 1'b1;
      end
      OP_ADDI: begin
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
        c.reg_data    = 1'b1;
      end
      OP_LD: begin
        c.alu_src          = 1'b1;
        c.alu_control      = ALU_ADD;
        c.reg_write_select = 1'b1;
      end
      OP_ST: begin
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_BEQ, OP_BNE: c.alu_control = ALU_SUB;
      OP_CALL: begin
        c.reg_to_pc   = 1'b1;
        c.reg_addr_1  = 5'd31;
        c.alu_control = ALU_ADD;
      end
      OP_RET: begin
        c.reg_addr_1  = 5'd31;
        c.alu_src     = 1'b1;
        c.imm         = 16'h0000;
        c.alu_control = ALU_ADD;
      end
      default: c.alu_control = 4'b0000;  // BR, HALT and undefined opcodes drive no ALU work
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_d;
  logic        illegal_q, illegal_d;
  logic        halted_q, halted_d;
  logic        we_q, we_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [5:0]  op_s;
  logic [31:0] npc_s;
  logic [31:0] target_s;

  assign op_s     = ir_q[31:26];
  assign npc_s    = pc_q + 32'd4;
  assign target_s = npc_s + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // Next state, PC, IR, flag and sticky-error update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: begin
        ir_d    = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = (op_s == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (op_s inside {OP_RALU, OP_SHIFT, OP_ADDI, OP_BEQ, OP_BNE}) begin
          flags_d = {zero_flag, carry_flag, sign_flag, overflow_flag};
        end else begin
          flags_d = flags_q;
        end
        case (op_s)
          OP_LD, OP_ST:                       state_d = S_MEM;
          OP_RALU, OP_SHIFT, OP_ADDI, OP_CALL: state_d = S_WB;
          OP_BR: begin
            pc_d    = target_s;
            state_d = S_FETCH;
          end
          OP_BEQ: begin
            pc_d    = zero_flag ? target_s : npc_s;
            state_d = S_FETCH;
          end
          OP_BNE: begin
            pc_d    = zero_flag ? npc_s : target_s;
            state_d = S_FETCH;
          end
          OP_RET: begin
            pc_d    = alu_result1;
            state_d = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            pc_d      = npc_s;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: state_d = S_MWAIT;
      S_MWAIT: begin
        if (op_s == OP_LD) begin
          state_d = S_WB;
        end else begin
          pc_d    = npc_s;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        pc_d    = (op_s == OP_CALL) ? target_s : npc_s;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Controls are pre-decoded from the next IR so they appear registered from DECODE on.
  always_comb begin
    ctrl_d   = '0;
    we_d     = 1'b0;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    halted_d = (state_d == S_HALT);
    if (state_d inside {S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB}) begin
      ctrl_d   = decode_ctrl(ir_d);
      we_d     = (state_d == S_WB);
      mem_rd_d = (state_d inside {S_MEM, S_MWAIT}) && (ir_d[31:26] == OP_LD);
      mem_wr_d = (state_d inside {S_MEM, S_MWAIT}) && (ir_d[31:26] == OP_ST);
    end else begin
      ctrl_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      we_q      <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      we_q      <= we_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // A reset arriving during WB must suppress that cycle's register write.
  assign regWriteEnable  = we_q & ~rst;
  assign regWrite_select = ctrl_q.reg_write_select;
  assign reg_to_pc       = ctrl_q.reg_to_pc;
  assign reg_data        = ctrl_q.reg_data;
  assign MemRead         = mem_rd_q;
  assign MemWrite        = mem_wr_q;
  assign ALU_src         = ctrl_q.alu_src;
  assign const_src       = ctrl_q.const_src;
  assign regAddr_1       = ctrl_q.reg_addr_1;
  assign regAddr_2       = ctrl_q.reg_addr_2;
  assign shift_amount    = ctrl_q.shift_amount;
  assign immediate_const = ctrl_q.imm;
  assign alu_control     = ctrl_q.alu_control;
  assign imem_addr       = pc_q;
  assign npc             = npc_s;
  assign halted          = halted_q;
  assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data, alu_result1, npc;
  logic        zero_flag, carry_flag, sign_flag, overflow_flag;
  logic        regWriteEnable, regWrite_select, reg_to_pc, reg_data;
  logic        MemRead, MemWrite, ALU_src, const_src;
  logic [4:0]  regAddr_1, regAddr_2;
  logic [5:0]  shift_amount;
  logic [15:0] immediate_const;
  logic [3:0]  alu_control, flags_q;
  logic        halted, illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem_mem [logic [31:0]];
  logic [31:0] cur_pc;
  logic [3:0]  exp_flags;
  logic        exp_ill;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_result1(alu_result1), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .sign_flag(sign_flag), .overflow_flag(overflow_flag),
    .regWriteEnable(regWriteEnable), .regWrite_select(regWrite_select),
    .reg_to_pc(reg_to_pc), .reg_data(reg_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_src(ALU_src), .const_src(const_src), .regAddr_1(regAddr_1), .regAddr_2(regAddr_2),
    .shift_amount(shift_amount), .immediate_const(immediate_const),
    .alu_control(alu_control), .npc(npc), .flags_q(flags_q), .halted(halted),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (!$isunknown(imem_addr) && imem_mem.exists(imem_addr)) imem_data <= imem_mem[imem_addr];
    else imem_data <= HALT_WORD;
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Places one instruction at the current PC, runs it to the next fetch and
  // compares what was seen with the instruction-level model.
  task automatic exec_and_check(input string name, input logic [31:0] instr,
                                input logic [3:0] fl, input logic [31:0] alu);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] tgt, exp_pc;
    int exp_lat, exp_we, exp_dest, exp_mr, exp_mw;
    logic exp_sel, exp_rd, exp_rtp, chk_alu, exp_src;
    logic [3:0] exp_alu;
    logic [4:0] exp_ra1;
    logic [15:0] exp_imm;
    int n, we_cnt, we_idx, mr_cnt, mw_cnt, dest;
    logic sel, rd, rtp, src;
    logic [31:0] wnpc;
    logic [3:0] alu_c;
    logic [4:0] ra1;
    logic [15:0] imm_o;

    imem_mem[cur_pc] = instr;
    {zero_flag, carry_flag, sign_flag, overflow_flag} = fl;
    alu_result1 = alu;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; imm = instr[15:0];
    tgt = cur_pc + 32'd4 + (32'(signed'(imm)) * 32'd4);

    exp_pc = cur_pc + 32'd4; exp_we = 0; exp_dest = 0; exp_sel = 1'b0; exp_rd = 1'b0;
    exp_rtp = 1'b0; exp_mr = 0; exp_mw = 0; exp_lat = 4; chk_alu = 1'b0;
    exp_alu = 4'd0; exp_src = 1'b0; exp_ra1 = rs; exp_imm = imm;
    case (op)
      6'h00: begin exp_lat = 5; exp_we = 1; exp_dest = rs; exp_rd = 1'b1; chk_alu = 1'b1; exp_alu = instr[3:0]; end
      6'h01: begin exp_lat = 5; exp_we = 1; exp_dest = rs; exp_rd = 1'b1; chk_alu = 1'b1; exp_alu = instr[3:0]; exp_src = 1'b1; end
      6'h02: begin exp_lat = 5; exp_we = 1; exp_dest = rs; exp_rd = 1'b1; chk_alu = 1'b1; exp_src = 1'b1; end
      6'h03: begin exp_lat = 7; exp_we = 1; exp_dest = rt; exp_sel = 1'b1; exp_mr = 2; chk_alu = 1'b1; exp_src = 1'b1; end
      6'h04: begin exp_lat = 6; exp_mw = 2; chk_alu = 1'b1; exp_src = 1'b1; end
      6'h05: exp_pc = tgt;
      6'h06: begin exp_pc = fl[3] ? tgt : cur_pc + 32'd4; chk_alu = 1'b1; exp_alu = 4'b0001; end
      6'h07: begin exp_pc = fl[3] ? cur_pc + 32'd4 : tgt; chk_alu = 1'b1; exp_alu = 4'b0001; end
      6'h08: begin exp_lat = 5; exp_we = 1; exp_dest = 31; exp_rtp = 1'b1; exp_pc = tgt; exp_ra1 = 5'd31; end
      6'h09: begin exp_pc = alu; chk_alu = 1'b1; exp_src = 1'b1; exp_ra1 = 5'd31; exp_imm = 16'h0000; end
      default: exp_ill = 1'b1;
    endcase
    if (op inside {6'h00, 6'h01, 6'h02, 6'h06, 6'h07}) exp_flags = fl;

    n = 0; we_cnt = 0; we_idx = -1; mr_cnt = 0; mw_cnt = 0; dest = -1;
    sel = 1'b0; rd = 1'b0; rtp = 1'b0; wnpc = 32'd0; alu_c = 4'd0; src = 1'b0;
    ra1 = 5'd0; imm_o = 16'd0;
    while (imem_addr === cur_pc && n < 20) begin
      if (regWriteEnable === 1'b1) begin
        we_cnt++; we_idx = n; sel = regWrite_select; rd = reg_data; rtp = reg_to_pc;
        dest = regWrite_select ? int'(regAddr_2) : int'(regAddr_1); wnpc = npc;
      end
      if (MemRead === 1'b1) mr_cnt++;
      if (MemWrite === 1'b1) mw_cnt++;
      if (n == 2) begin alu_c = alu_control; src = ALU_src; ra1 = regAddr_1; imm_o = immediate_const; end
      @(negedge clk);
      n++;
    end

    n_tests++; if (n !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d, want %0d", name, n, exp_lat); end
    n_tests++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL %s next_pc: got %h, want %h", name, imem_addr, exp_pc); end
    n_tests++; if (we_cnt !== exp_we) begin n_fail++; $display("FAIL %s we_count: got %0d, want %0d", name, we_cnt, exp_we); end
    n_tests++; if (mr_cnt !== exp_mr) begin n_fail++; $display("FAIL %s memread_cycles: got %0d, want %0d", name, mr_cnt, exp_mr); end
    n_tests++; if (mw_cnt !== exp_mw) begin n_fail++; $display("FAIL %s memwrite_cycles: got %0d, want %0d", name, mw_cnt, exp_mw); end
    n_tests++; if (flags_q !== exp_flags) begin n_fail++; $display("FAIL %s flags_q: got %b, want %b", name, flags_q, exp_flags); end
    n_tests++; if (illegal_op !== exp_ill) begin n_fail++; $display("FAIL %s illegal_op: got %b, want %b", name, illegal_op, exp_ill); end
    if (exp_we == 1) begin
      n_tests++; if (we_idx !== exp_lat - 1) begin n_fail++; $display("FAIL %s we_cycle: got %0d, want %0d", name, we_idx, exp_lat - 1); end
      n_tests++; if (dest !== exp_dest) begin n_fail++; $display("FAIL %s dest_reg: got %0d, want %0d", name, dest, exp_dest); end
      n_tests++; if (sel !== exp_sel) begin n_fail++; $display("FAIL %s regWrite_select: got %b, want %b", name, sel, exp_sel); end
      n_tests++; if (rtp !== exp_rtp) begin n_fail++; $display("FAIL %s reg_to_pc: got %b, want %b", name, rtp, exp_rtp); end
      n_tests++; if (wnpc !== cur_pc + 32'd4) begin n_fail++; $display("FAIL %s npc_at_wb: got %h, want %h", name, wnpc, cur_pc + 32'd4); end
      if (op != 6'h08) begin
        n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL %s reg_data: got %b, want %b", name, rd, exp_rd); end
      end
    end
    if (chk_alu || op == 6'h08) begin
      n_tests++; if (ra1 !== exp_ra1) begin n_fail++; $display("FAIL %s regAddr_1: got %0d, want %0d", name, ra1, exp_ra1); end
    end
    if (chk_alu) begin
      n_tests++; if (alu_c !== exp_alu) begin n_fail++; $display("FAIL %s alu_control: got %h, want %h", name, alu_c, exp_alu); end
      n_tests++; if (src !== exp_src) begin n_fail++; $display("FAIL %s ALU_src: got %b, want %b", name, src, exp_src); end
      n_tests++; if (imm_o !== exp_imm) begin n_fail++; $display("FAIL %s immediate: got %h, want %h", name, imm_o, exp_imm); end
    end
    cur_pc = exp_pc;
  endtask

  task automatic goto_pc(input logic [31:0] t);
    logic [31:0] d;
    d = t - cur_pc - 32'd4;
    exec_and_check("goto", mk(6'h05, 5'd0, 5'd0, d[17:2]), 4'b0000, 32'd0);
  endtask

  task automatic test_reset();
    logic [52:0] ctl;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ctl = {regWriteEnable, regWrite_select, reg_to_pc, reg_data, MemRead, MemWrite, ALU_src,
             const_src, regAddr_1, regAddr_2, shift_amount, immediate_const, alu_control};
      n_tests++; if (ctl !== 53'd0) begin n_fail++; $display("FAIL reset_controls: got %h, want 0", ctl); end
      n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h, want 0", imem_addr); end
      n_tests++; if ({halted, illegal_op, flags_q} !== 6'd0) begin n_fail++; $display("FAIL reset_status: got %b, want 0", {halted, illegal_op, flags_q}); end
    end
    n_tests++; if (npc !== 32'd4) begin n_fail++; $display("FAIL reset_npc: got %h, want 4", npc); end
    rst = 1'b0;
    cur_pc = 32'd0; exp_flags = 4'd0; exp_ill = 1'b0;
  endtask

  task automatic test_r_alu();
    exec_and_check("ralu_add", mk(6'h00, 5'd1, 5'd2, 16'h0000), 4'b1010, 32'd0);
  endtask

  task automatic test_load();
    exec_and_check("ld_neg", mk(6'h03, 5'd5, 5'd3, 16'hFFFC), 4'b1111, 32'd0);
  endtask

  task automatic test_branch();
    exec_and_check("beq_taken", mk(6'h06, 5'd1, 5'd2, 16'd3), 4'b1000, 32'd0);
    goto_pc(32'd8);
    exec_and_check("beq_not", mk(6'h06, 5'd1, 5'd2, 16'd3), 4'b0100, 32'd0);
    goto_pc(32'd8);
    exec_and_check("bne_not", mk(6'h07, 5'd1, 5'd2, 16'd3), 4'b1001, 32'd0);
    goto_pc(32'd8);
    exec_and_check("bne_taken", mk(6'h07, 5'd1, 5'd2, 16'd3), 4'b0010, 32'd0);
  endtask

  task automatic test_call_ret();
    goto_pc(32'h40);
    exec_and_check("call", mk(6'h08, 5'd4, 5'd6, 16'h0010), 4'b0000, 32'd0);
    exec_and_check("ret", mk(6'h09, 5'd7, 5'd8, 16'h1234), 4'b0000, 32'h44);
  endtask

  task automatic test_illegal();
    exec_and_check("illegal_2a", mk(6'h2A, 5'd1, 5'd1, 16'h0000), 4'b0000, 32'd0);
    exec_and_check("after_illegal", mk(6'h02, 5'd9, 5'd0, 16'h0005), 4'b0001, 32'd0);
  endtask

  task automatic test_pc_wrap();
    exec_and_check("ret_top", mk(6'h09, 5'd0, 5'd0, 16'h0000), 4'b0000, 32'hFFFF_FFFC);
    exec_and_check("wrap_addi", mk(6'h02, 5'd2, 5'd0, 16'h0001), 4'b0110, 32'd0);
  endtask

  task automatic test_reset_mid_load();
    imem_mem[cur_pc] = mk(6'h03, 5'd1, 5'd4, 16'h0008);
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_tests++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL midload_memread: got %b, want 1", MemRead); end
    rst = 1'b1;
    #1;
    n_tests++; if (regWriteEnable !== 1'b0) begin n_fail++; $display("FAIL midload_we_rst: got %b, want 0", regWriteEnable); end
    @(negedge clk);
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL midload_pc: got %h, want 0", imem_addr); end
    n_tests++; if ({regWriteEnable, MemRead, illegal_op} !== 3'b000) begin n_fail++; $display("FAIL midload_ctl: got %b, want 000", {regWriteEnable, MemRead, illegal_op}); end
    rst = 1'b0;
    cur_pc = 32'd0; exp_flags = 4'd0; exp_ill = 1'b0;
    exec_and_check("post_reset", mk(6'h00, 5'd3, 5'd4, 16'h0001), 4'b0011, 32'd0);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [15:0] imm;
    logic [31:0] alu, rnd;
    for (int i = 0; i < 60; i++) begin
      op = 6'($urandom_range(0, 10));
      if (op == 6'd10) op = 6'($urandom_range(10, 62));
      imm = 16'($urandom);
      if (imm == 16'hFFFF) imm = 16'h0001;
      rnd = $urandom;
      alu = {rnd[31:2], 2'b00};
      if (alu == cur_pc) alu = alu + 32'd4;
      exec_and_check("random", mk(op, 5'($urandom), 5'($urandom), imm), 4'($urandom), alu);
    end
  endtask

  task automatic test_halt();
    int bad_addr, bad_halt, bad_we;
    imem_mem[cur_pc] = HALT_WORD;
    bad_addr = 0; bad_halt = 0; bad_we = 0;
    for (int n = 0; n < 23; n++) begin
      if (imem_addr !== cur_pc) bad_addr++;
      if (n >= 3 && halted !== 1'b1) bad_halt++;
      if (regWriteEnable !== 1'b0) bad_we++;
      @(negedge clk);
    end
    n_tests++; if (bad_addr !== 0) begin n_fail++; $display("FAIL halt_pc_frozen: got %0d moved cycles, want 0", bad_addr); end
    n_tests++; if (bad_halt !== 0) begin n_fail++; $display("FAIL halt_flag: got %0d low cycles, want 0", bad_halt); end
    n_tests++; if (bad_we !== 0) begin n_fail++; $display("FAIL halt_no_write: got %0d write cycles, want 0", bad_we); end
  endtask

  initial begin
    rst = 1'b1;
    alu_result1 = 32'd0;
    {zero_flag, carry_flag, sign_flag, overflow_flag} = 4'b0000;
    test_reset();
    test_r_alu();
    test_load();
    test_branch();
    test_call_ret();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_load();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
